// File: rtl/multdiv_shift_reg.sv
// Iterative {hi, lo} working register for the multdiv unit: parallel load, per-cycle
// SRA1 / SRA2 / SLL-with-insert under op control, upper-half merge, built-in step counter.
module multdiv_shift_reg #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic               i_clk,
  input  logic               i_clr_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_in,
  input  logic [CNT_W-1:0]   i_iters,
  input  logic [1:0]         i_op,
  input  logic               i_hi_wr,
  input  logic [WIDTH/2-1:0] i_hi_in,
  input  logic               i_ins_bit,
  input  logic               i_out_en,
  output logic [WIDTH-1:0]   o_out,
  output logic [WIDTH-1:0]   o_raw,
  output logic               o_busy,
  output logic               o_done
);

  localparam int HALF = WIDTH / 2;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_v;
  logic [WIDTH-1:0] w_step;

  // Merged operand (adder result into upper half) and its shifted form for this cycle
  always_comb begin
    w_v    = r_reg;
    w_step = r_reg;
    if (i_hi_wr) begin
      w_v = {i_hi_in, r_reg[HALF-1:0]};
    end else begin
      w_v = r_reg;
    end
    case (i_op)
      2'b01:   w_step = {w_v[WIDTH-1], w_v[WIDTH-1:1]};
      2'b10:   w_step = {w_v[WIDTH-1], w_v[WIDTH-1], w_v[WIDTH-1:2]};
      2'b11:   w_step = {w_v[WIDTH-2:0], i_ins_bit};
      default: w_step = w_v;
    endcase
  end

  // Register, step counter and busy/done; start wins over any step in progress
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_reg  <= {WIDTH{1'b0}};
      r_cnt  <= CNT_ZERO;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_reg  <= i_in;
      r_cnt  <= i_iters;
      r_busy <= (i_iters != CNT_ZERO);
      r_done <= (i_iters == CNT_ZERO);
    end else if (r_busy) begin
      if (i_op != 2'b00) begin
        r_reg <= w_step;
        r_cnt <= r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_busy <= 1'b1;
          r_done <= 1'b0;
        end
      end else begin
        // stall cycle: merge only, count untouched
        r_reg  <= w_v;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_raw  = r_reg;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_out  = i_out_en ? r_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_multdiv_shift_reg.sv
// Bench for multdiv_shift_reg (WIDTH=8): directed vector table, reset/restart sequences,
// and random traffic checked against an arithmetic reference model.
module tb_multdiv_shift_reg;

  localparam int W  = 8;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr_n, start, hi_wr, ins_bit, out_en;
  logic [W-1:0]  in_v;
  logic [CW-1:0] iters;
  logic [1:0]    op;
  logic [W/2-1:0] hi_in;
  wire  [W-1:0]  out_w;
  logic [W-1:0]  raw;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_reg;
  int           m_left;
  logic         m_done;

  multdiv_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk(clk), .i_clr_n(clr_n), .i_start(start), .i_in(in_v), .i_iters(iters),
    .i_op(op), .i_hi_wr(hi_wr), .i_hi_in(hi_in), .i_ins_bit(ins_bit), .i_out_en(out_en),
    .o_out(out_w), .o_raw(raw), .o_busy(busy), .o_done(done)
  );

  typedef struct {
    logic          st;
    logic [W-1:0]  din;
    logic [CW-1:0] it;
    logic [1:0]    op;
    logic          hw;
    logic [3:0]    hi;
    logic          ib;
    logic          oe;
    logic [W-1:0]  e_raw;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic st, logic [W-1:0] din, logic [CW-1:0] it, logic [1:0] o,
                              logic hw, logic [3:0] hi, logic ib, logic oe,
                              logic [W-1:0] er, logic eb, logic ed);
    vec_t v;
    v.st = st; v.din = din; v.it = it; v.op = o; v.hw = hw; v.hi = hi; v.ib = ib; v.oe = oe;
    v.e_raw = er; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string name, logic [W-1:0] exp);
    checks++;
    if (out_en) begin
      if (out_w !== exp) begin
        errors++;
        $display("FAIL %s actual=%0h required=%0h", name, out_w, exp);
      end
    end else if (!($isunknown(out_w) || out_w == 8'h00)) begin
      errors++;
      $display("FAIL %s actual=%0h required=z", name, out_w);
    end
  endtask

  // Reference behaviour at a rising edge, computed from the arithmetic meaning of each op
  task automatic model_edge();
    logic [W-1:0] v;
    if (start) begin
      m_reg  = in_v;
      m_left = int'(iters);
      m_done = (iters == 6'd0);
    end else if (m_left > 0) begin
      v = m_reg;
      if (hi_wr) v[W-1:W/2] = hi_in;
      m_done = 1'b0;
      if (op == 2'b01)      m_reg = $signed(v) >>> 1;
      else if (op == 2'b10) m_reg = $signed(v) >>> 2;
      else if (op == 2'b11) m_reg = (v << 1) | {7'd0, ins_bit};
      else                  m_reg = v;
      if (op != 2'b00) begin
        m_left = m_left - 1;
        m_done = (m_left == 0);
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; in_v = 8'h00; iters = 6'd0; op = 2'b00;
    hi_wr = 1'b0; hi_in = 4'h0; ins_bit = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 8'hA4, 6'd3, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 8'h00, 6'd0, 2'b01, 1'b0, 4'h0, 1'b0, 1'b0, 8'hD2, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 8'h00, 6'd0, 2'b01, 1'b0, 4'h0, 1'b0, 1'b1, 8'hE9, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 8'h00, 6'd0, 2'b01, 1'b0, 4'h0, 1'b0, 1'b0, 8'hF4, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 8'h00, 6'd0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 8'h0F, 6'd1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 8'h00, 6'd0, 2'b10, 1'b1, 4'h6, 1'b0, 1'b1, 8'h1B, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 8'h00, 6'd0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 8'h1B, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 8'h81, 6'd2, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 8'h00, 6'd0, 2'b11, 1'b0, 4'h0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 8'h00, 6'd0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 8'h00, 6'd0, 2'b11, 1'b0, 4'h0, 1'b0, 1'b1, 8'h06, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 8'h00, 6'd0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'h06, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 8'h3C, 6'd0, 2'b01, 1'b1, 4'h9, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 8'h00, 6'd0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 8'hF0, 6'd4, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 8'h00, 6'd0, 2'b01, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF8, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, 8'h00, 6'd0, 2'b01, 1'b0, 4'h0, 1'b0, 1'b1, 8'hFC, 1'b1, 1'b0);
    tbl[18] = mk(1'b1, 8'h55, 6'd1, 2'b01, 1'b0, 4'h0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    tbl[19] = mk(1'b0, 8'h00, 6'd0, 2'b01, 1'b0, 4'h0, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b1);
    tbl[20] = mk(1'b0, 8'h00, 6'd0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0);
    tbl[21] = mk(1'b0, 8'h00, 6'd0, 2'b11, 1'b1, 4'hF, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b0);
    tbl[22] = mk(1'b0, 8'h00, 6'd0, 2'b11, 1'b1, 4'hF, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0);
    tbl[23] = mk(1'b0, 8'h00, 6'd0, 2'b11, 1'b1, 4'hF, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b0);
    tbl[24] = mk(1'b0, 8'h00, 6'd0, 2'b11, 1'b1, 4'hF, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0);
    tbl[25] = mk(1'b0, 8'h00, 6'd0, 2'b11, 1'b1, 4'hF, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b0);
    tbl[26] = mk(1'b1, 8'h12, 6'd1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0);
    tbl[27] = mk(1'b0, 8'h00, 6'd0, 2'b00, 1'b1, 4'hA, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0);
    tbl[28] = mk(1'b0, 8'h00, 6'd0, 2'b11, 1'b0, 4'h0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1);

    clr_n = 1'b0; out_en = 1'b1;
    idle_inputs();
    m_reg = 8'h00; m_left = 0; m_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_raw", raw, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_done", {7'd0, done}, 8'h00);
    chk_out("reset_out", 8'h00);
    clr_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      start = tbl[i].st; in_v = tbl[i].din; iters = tbl[i].it; op = tbl[i].op;
      hi_wr = tbl[i].hw; hi_in = tbl[i].hi; ins_bit = tbl[i].ib; out_en = tbl[i].oe;
      step();
      chk($sformatf("vec%0d_raw", i), raw, tbl[i].e_raw);
      chk($sformatf("vec%0d_busy", i), {7'd0, busy}, {7'd0, tbl[i].e_busy});
      chk($sformatf("vec%0d_done", i), {7'd0, done}, {7'd0, tbl[i].e_done});
      chk_out($sformatf("vec%0d_out", i), tbl[i].e_raw);
    end

    // Asynchronous reset in the middle of a run
    idle_inputs(); out_en = 1'b1;
    start = 1'b1; in_v = 8'hA4; iters = 6'd5;
    step();
    start = 1'b0; op = 2'b01;
    step();
    step();
    chk("pre_reset_busy", {7'd0, busy}, 8'h01);
    clr_n = 1'b0;
    #1;
    m_reg = 8'h00; m_left = 0; m_done = 1'b0;
    chk("async_rst_raw", raw, 8'h00);
    chk("async_rst_busy", {7'd0, busy}, 8'h00);
    chk("async_rst_done", {7'd0, done}, 8'h00);
    chk_out("async_rst_out_en1", 8'h00);
    out_en = 1'b0;
    #1;
    chk_out("async_rst_out_en0", 8'h00);
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst%0d_done", i), {7'd0, done}, 8'h00);
      chk($sformatf("post_rst%0d_raw", i), raw, 8'h00);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      in_v    = 8'($urandom);
      iters   = 6'($urandom_range(0, 6));
      op      = 2'($urandom);
      hi_wr   = 1'($urandom);
      hi_in   = 4'($urandom);
      ins_bit = 1'($urandom);
      out_en  = 1'($urandom);
      step();
      chk($sformatf("rnd%0d_raw", i), raw, m_reg);
      chk($sformatf("rnd%0d_busy", i), {7'd0, busy}, {7'd0, (m_left > 0)});
      chk($sformatf("rnd%0d_done", i), {7'd0, done}, {7'd0, m_done});
      chk_out($sformatf("rnd%0d_out", i), m_reg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_shift_reg.md
# multdiv_shift_reg

Parametrised iterative working register for the multdiv unit: holds the combined {hi, lo} product/remainder-quotient word, shifts it under per-cycle op control (SRA by 1, SRA by 2 for radix-4 Booth, SLL by 1 with quotient-bit insert), and optionally merges a new upper half from the adder before each shift. An internal step counter tracks a programmed iteration count and raises busy/done, so the multdiv controller needs no separate counter. Output is available raw and through a tri-state bus driver, like the other multdiv storage registers.

## Interface
- WIDTH, 64, register width; even, >= 4
- CNT_W, 6, width of iteration count and internal step counter
- clk  in  1  clock, all state updates on rising edge
- clr_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  load `in` into the register, load `iters` into the counter
- in  in  WIDTH  parallel load value
- iters  in  CNT_W  number of shift steps to run after start
- op  in  2  00 hold, 01 SRA by 1, 10 SRA by 2, 11 SLL by 1
- hi_wr  in  1  replace upper half with hi_in before applying op
- hi_in  in  WIDTH/2  new upper half (adder result)
- ins_bit  in  1  bit shifted into LSB on SLL
- out_en  in  1  tri-state output enable
- out  out  WIDTH  register value when out_en=1, else all z
- raw  out  WIDTH  register value, always driven
- busy  out  1  steps remaining
- done  out  1  one-cycle pulse after final step

## Operation
- State: reg[WIDTH-1:0], cnt[CNT_W-1:0], busy, done.
- Reset (clr_n=0, asynchronous): reg=0, cnt=0, busy=0, done=0; raw=0; out=0 if out_en else z. Reset mid-run aborts; no done pulse.
- start=1 (highest priority, accepted busy or idle): reg<=in, cnt<=iters, busy<=(iters!=0), done<=(iters==0). op/hi_wr ignored that cycle. Restart while busy discards the run in progress; no done for it.
- Step: a cycle with busy=1, start=0, op!=00. Operand v = hi_wr ? {hi_in, reg[WIDTH/2-1:0]} : reg.
  - 01: reg <= {v[W-1], v[W-1:1]}
  - 10: reg <= {v[W-1], v[W-1], v[W-1:2]}
  - 11: reg <= {v[W-2:0], ins_bit}
  - cnt<=cnt-1; if cnt==1: busy<=0, done<=1.
- busy=1, op=00: hold; if hi_wr, reg upper half <= hi_in; cnt unchanged (merge without step).
- busy=0, start=0: reg holds; op, hi_wr, hi_in, ins_bit ignored.
- done is 1 for exactly one cycle; cleared the following cycle unless start with iters==0 reasserts it.
- out is pure combinational tri-state of reg; out_en does not affect state.

## Timing
- start at edge N: raw=in after edge N; busy=1 from edge N if iters!=0.
- Each step takes effect on its rising edge; raw reflects it same cycle afterward.
- With op!=00 every cycle, final step at edge N+iters; busy falls and done rises at that edge; done falls at edge N+iters+1.
- iters=0: done high for the cycle following start edge; busy never asserted.
- Stalls (op=00 while busy) extend the run one cycle each.
- cnt never wraps: steps only occur while busy, busy only with cnt>=1.
- out_en to out: combinational, no latency.

## Test plan
- Reset: drive clr_n=0 mid-run with out_en=1 -> raw=0, out=0, busy=0, done=0 immediately, no done pulse after release; out_en=0 -> out=z.
- SRA1 run, WIDTH=8: start in=8'hA4 iters=3, op=01 x3 -> raw 8'hD2, 8'hE9, 8'hF4; busy 1 for 3 cycles; done one pulse on cycle after third step.
- SRA2 with merge, WIDTH=8: start in=8'h0F iters=1, op=10 hi_wr=1 hi_in=4'h6 -> v=8'h6F, raw=8'h1B, done pulses.
- SLL divide, WIDTH=8: start in=8'h81 iters=2, op=11 ins_bit=1 then 0 -> raw 8'h03, 8'h06; stall cycle (op=00) between steps holds raw and delays done one cycle.
- iters=0 and restart: start iters=0 -> done one cycle, busy 0; start iters=4, after 2 steps start again in=8'h55 iters=1 -> raw=8'h55, only one done (after the single step).
- Idle ignore: busy=0, op=11 hi_wr=1 for 5 cycles -> raw unchanged, done stays 0; out toggles value/z with out_en.
